// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 responder backed by a 64-bit word memory.
// Independent read and write FSMs, one outstanding transaction each.
// Ports:
//   clk, rst                      clock, async active-high reset
//   axi_aw_*  (id/addr/len/size/burst/valid -> ready)   write address
//   axi_w_*   (data/strb/last/valid -> ready)           write data
//   axi_b_*   (id/resp/valid <- ready)                  write response
//   axi_ar_*  (id/addr/len/size/burst/valid -> ready)   read address
//   axi_r_*   (id/data/resp/last/valid <- ready)        read data
// Word index = (addr - BASE) >> 3; size and addr[2:0] are ignored.
module axi_mem_slave #(
    parameter int unsigned       ID_W   = 4,
    parameter int unsigned       ADDR_W = 32,
    parameter int unsigned       DEPTH  = 65536,
    parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
    parameter int unsigned       RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   axi_aw_id,
    input  logic [ADDR_W-1:0] axi_aw_addr,
    input  logic [7:0]        axi_aw_len,
    input  logic [2:0]        axi_aw_size,
    input  logic [1:0]        axi_aw_burst,
    input  logic              axi_aw_valid,
    output logic              axi_aw_ready,
    input  logic [63:0]       axi_w_data,
    input  logic [7:0]        axi_w_strb,
    input  logic              axi_w_last,
    input  logic              axi_w_valid,
    output logic              axi_w_ready,
    output logic [ID_W-1:0]   axi_b_id,
    output logic [1:0]        axi_b_resp,
    output logic              axi_b_valid,
    input  logic              axi_b_ready,
    input  logic [ID_W-1:0]   axi_ar_id,
    input  logic [ADDR_W-1:0] axi_ar_addr,
    input  logic [7:0]        axi_ar_len,
    input  logic [2:0]        axi_ar_size,
    input  logic [1:0]        axi_ar_burst,
    input  logic              axi_ar_valid,
    output logic              axi_ar_ready,
    output logic [ID_W-1:0]   axi_r_id,
    output logic [63:0]       axi_r_data,
    output logic [1:0]        axi_r_resp,
    output logic              axi_r_last,
    output logic              axi_r_valid,
    input  logic              axi_r_ready
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) + 1 : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    logic [63:0] mem [DEPTH];

    function automatic logic hit(input logic [ADDR_W-1:0] a);
        return (a >= BASE) && (((a - BASE) >> 3) < ADDR_W'(DEPTH));
    endfunction

    // Truncation gives the mod-DEPTH wrap inside in-range bursts.
    function automatic logic [IDX_W-1:0] widx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> 3);
    endfunction

    // Response codes are ordered by severity, so worst == numeric max.
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic unused_ok;
    assign unused_ok = ^{axi_aw_size, axi_ar_size, axi_aw_addr[2:0], axi_ar_addr[2:0]};

    // ---------------- write path ----------------
    w_state_e          w_state_q;
    logic              aw_ready_q, w_ready_q, b_valid_q, w_sin_q;
    logic [ID_W-1:0]   b_id_q, w_id_q;
    logic [1:0]        b_resp_q, w_acc_q, w_burst_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [7:0]        w_len_q, w_beat_q;

    logic       w_hs, w_in, w_bok, w_we;
    logic [1:0] w_resp;

    assign w_hs   = w_ready_q & axi_w_valid;
    assign w_in   = w_sin_q | hit(w_addr_q);
    assign w_bok  = (w_burst_q == BURST_INCR) || (w_burst_q == BURST_FIXED);
    assign w_resp = !w_in ? RESP_DECERR :
                    (!w_bok || (axi_w_last != (w_beat_q == w_len_q))) ? RESP_SLVERR : RESP_OKAY;
    assign w_we   = w_hs & w_in & w_bok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            b_resp_q   <= RESP_OKAY;
            w_id_q     <= '0;
            w_addr_q   <= '0;
            w_sin_q    <= 1'b0;
            w_len_q    <= '0;
            w_beat_q   <= '0;
            w_burst_q  <= '0;
            w_acc_q    <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: if (aw_ready_q && axi_aw_valid) begin
                    w_id_q     <= axi_aw_id;
                    w_addr_q   <= {axi_aw_addr[ADDR_W-1:3], 3'b000};
                    w_sin_q    <= hit({axi_aw_addr[ADDR_W-1:3], 3'b000});
                    w_len_q    <= axi_aw_len;
                    w_burst_q  <= axi_aw_burst;
                    w_beat_q   <= '0;
                    w_acc_q    <= RESP_OKAY;
                    aw_ready_q <= 1'b0;
                    w_ready_q  <= 1'b1;
                    w_state_q  <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    if (w_beat_q == w_len_q) begin
                        w_ready_q <= 1'b0;
                        b_valid_q <= 1'b1;
                        b_id_q    <= w_id_q;
                        b_resp_q  <= worst(w_acc_q, w_resp);
                        w_state_q <= W_RESP;
                    end else begin
                        w_acc_q  <= worst(w_acc_q, w_resp);
                        w_beat_q <= w_beat_q + 8'd1;
                        if (w_burst_q == BURST_INCR) w_addr_q <= w_addr_q + ADDR_W'(8);
                    end
                end
                W_RESP: if (axi_b_ready) begin
                    b_valid_q  <= 1'b0;
                    aw_ready_q <= 1'b1;
                    w_state_q  <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Memory is never reset; its contents survive a reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 8; i++) begin
                if (axi_w_strb[i]) mem[widx(w_addr_q)][8*i +: 8] <= axi_w_data[8*i +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_e          r_state_q;
    logic              ar_ready_q, r_valid_q, r_last_q, r_sin_q;
    logic [ID_W-1:0]   r_id_q;
    logic [63:0]       r_data_q;
    logic [1:0]        r_resp_q, r_burst_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [7:0]        r_len_q, r_beat_q;
    logic [CNT_W-1:0]  r_cnt_q;

    // Fetch candidate: the beat that gets loaded into the r_* registers when r_fetch fires.
    logic [ADDR_W-1:0] ar_addr_al, f_addr;
    logic [7:0]        f_beat, f_len;
    logic [1:0]        f_burst, f_resp;
    logic              f_sin, f_in, f_bok, ar_hs, r_fetch;

    assign ar_addr_al = {axi_ar_addr[ADDR_W-1:3], 3'b000};
    assign ar_hs      = ar_ready_q & axi_ar_valid;

    always_comb begin
        f_addr  = r_addr_q;
        f_beat  = r_beat_q;
        f_len   = r_len_q;
        f_burst = r_burst_q;
        f_sin   = r_sin_q;
        if (r_state_q == R_IDLE) begin
            f_addr  = ar_addr_al;
            f_beat  = '0;
            f_len   = axi_ar_len;
            f_burst = axi_ar_burst;
            f_sin   = hit(ar_addr_al);
        end else if (r_state_q == R_DATA) begin
            f_beat = r_beat_q + 8'd1;
            if (r_burst_q == BURST_INCR) f_addr = r_addr_q + ADDR_W'(8);
        end
    end

    assign f_in    = f_sin | hit(f_addr);
    assign f_bok   = (f_burst == BURST_INCR) || (f_burst == BURST_FIXED);
    assign f_resp  = !f_in ? RESP_DECERR : !f_bok ? RESP_SLVERR : RESP_OKAY;
    assign r_fetch = ((r_state_q == R_IDLE) && ar_hs && (RD_LAT == 1)) ||
                     ((r_state_q == R_WAIT) && (r_cnt_q == CNT_W'(1))) ||
                     ((r_state_q == R_DATA) && axi_r_ready && !r_last_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= R_IDLE;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_id_q     <= '0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            r_addr_q   <= '0;
            r_sin_q    <= 1'b0;
            r_len_q    <= '0;
            r_beat_q   <= '0;
            r_burst_q  <= '0;
            r_cnt_q    <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: if (ar_hs) begin
                    r_id_q     <= axi_ar_id;
                    r_addr_q   <= ar_addr_al;
                    r_sin_q    <= hit(ar_addr_al);
                    r_len_q    <= axi_ar_len;
                    r_burst_q  <= axi_ar_burst;
                    r_beat_q   <= '0;
                    r_cnt_q    <= CNT_W'(RD_LAT - 1);
                    ar_ready_q <= 1'b0;
                    r_state_q  <= (RD_LAT == 1) ? R_DATA : R_WAIT;
                end
                R_WAIT: begin
                    r_cnt_q <= r_cnt_q - CNT_W'(1);
                    if (r_cnt_q == CNT_W'(1)) r_state_q <= R_DATA;
                end
                R_DATA: if (axi_r_ready && r_last_q) begin
                    r_valid_q  <= 1'b0;
                    r_last_q   <= 1'b0;
                    ar_ready_q <= 1'b1;
                    r_state_q  <= R_IDLE;
                end
                default: r_state_q <= R_IDLE;
            endcase
            // Reads sample mem before this edge's write lands: read-before-write.
            if (r_fetch) begin
                r_valid_q <= 1'b1;
                r_data_q  <= (f_in && f_bok) ? mem[widx(f_addr)] : '0;
                r_resp_q  <= f_resp;
                r_last_q  <= (f_beat == f_len);
                r_addr_q  <= f_addr;
                r_beat_q  <= f_beat;
            end
        end
    end

    assign axi_aw_ready = aw_ready_q;
    assign axi_w_ready  = w_ready_q;
    assign axi_b_id     = b_id_q;
    assign axi_b_resp   = b_resp_q;
    assign axi_b_valid  = b_valid_q;
    assign axi_ar_ready = ar_ready_q;
    assign axi_r_id     = r_id_q;
    assign axi_r_data   = r_data_q;
    assign axi_r_resp   = r_resp_q;
    assign axi_r_last   = r_last_q;
    assign axi_r_valid  = r_valid_q;
endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  aw_id, ar_id, b_id, r_id;
    logic [31:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [2:0]  aw_size, ar_size;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
    logic [63:0] w_data, r_data;

    int unsigned nvec = 0;
    int unsigned nbad = 0;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    always #5 clk = ~clk;

    axi_mem_slave dut (
        .clk(clk), .rst(rst),
        .axi_aw_id(aw_id), .axi_aw_addr(aw_addr), .axi_aw_len(aw_len), .axi_aw_size(aw_size),
        .axi_aw_burst(aw_burst), .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready),
        .axi_w_data(w_data), .axi_w_strb(w_strb), .axi_w_last(w_last), .axi_w_valid(w_valid),
        .axi_w_ready(w_ready),
        .axi_b_id(b_id), .axi_b_resp(b_resp), .axi_b_valid(b_valid), .axi_b_ready(b_ready),
        .axi_ar_id(ar_id), .axi_ar_addr(ar_addr), .axi_ar_len(ar_len), .axi_ar_size(ar_size),
        .axi_ar_burst(ar_burst), .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready),
        .axi_r_id(r_id), .axi_r_data(r_data), .axi_r_resp(r_resp), .axi_r_last(r_last),
        .axi_r_valid(r_valid), .axi_r_ready(r_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int n = 0;
        aw_id = id; aw_addr = addr; aw_len = len; aw_burst = burst; aw_valid = 1'b1;
        while (!aw_ready && n < 20) begin tick(); n++; end
        if (n == 20) chk("aw_ready_wait", {63'd0, aw_ready}, 64'd1);
        tick();
        aw_valid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
        while (!w_ready && n < 20) begin tick(); n++; end
        if (n == 20) chk("w_ready_wait", {63'd0, w_ready}, 64'd1);
        tick();
        w_valid = 1'b0;
    endtask

    task automatic b_take(input logic [3:0] id, input logic [1:0] resp);
        chk("b_valid", {63'd0, b_valid}, 64'd1);
        chk("b_id", {60'd0, b_id}, {60'd0, id});
        chk("b_resp", {62'd0, b_resp}, {62'd0, resp});
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        chk("b_valid_drop", {63'd0, b_valid}, 64'd0);
        chk("aw_ready_back", {63'd0, aw_ready}, 64'd1);
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int n = 0;
        ar_id = id; ar_addr = addr; ar_len = len; ar_burst = burst; ar_valid = 1'b1;
        while (!ar_ready && n < 20) begin tick(); n++; end
        if (n == 20) chk("ar_ready_wait", {63'd0, ar_ready}, 64'd1);
        tick();
        ar_valid = 1'b0;
    endtask

    // Single-beat read with the RD_LAT=2 timing check.
    task automatic read1(input string tag, input logic [3:0] id, input logic [31:0] addr,
                         input logic [63:0] data, input logic [1:0] resp);
        ar_send(id, addr, 8'd0, INCR);
        chk({tag, "_rvalid_early"}, {63'd0, r_valid}, 64'd0);
        tick();
        chk({tag, "_rvalid"}, {63'd0, r_valid}, 64'd1);
        chk({tag, "_rdata"}, r_data, data);
        chk({tag, "_rresp"}, {62'd0, r_resp}, {62'd0, resp});
        chk({tag, "_rlast"}, {63'd0, r_last}, 64'd1);
        chk({tag, "_rid"}, {60'd0, r_id}, {60'd0, id});
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        chk({tag, "_rvalid_drop"}, {63'd0, r_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = 3'd3; aw_burst = INCR; aw_valid = 1'b0;
        ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = 3'd3; ar_burst = INCR; ar_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
        #2;
        chk("rst_aw_ready", {63'd0, aw_ready}, 64'd1);
        chk("rst_ar_ready", {63'd0, ar_ready}, 64'd1);
        chk("rst_w_ready", {63'd0, w_ready}, 64'd0);
        chk("rst_b_valid", {63'd0, b_valid}, 64'd0);
        chk("rst_r_valid", {63'd0, r_valid}, 64'd0);
        chk("rst_r_last", {63'd0, r_last}, 64'd0);
        chk("rst_r_data", r_data, 64'd0);
        chk("rst_b_resp", {62'd0, b_resp}, 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1. single write then read back
        aw_send(4'd5, 32'h8000_0010, 8'd0, INCR);
        chk("t1_w_ready", {63'd0, w_ready}, 64'd1);
        chk("t1_aw_ready_busy", {63'd0, aw_ready}, 64'd0);
        w_send(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
        b_take(4'd5, 2'b00);
        read1("t1", 4'd3, 32'h8000_0010, 64'h1122_3344_5566_7788, 2'b00);

        // 2. partial strobe over a zeroed word
        aw_send(4'd1, 32'h8000_0020, 8'd0, INCR);
        w_send(64'd0, 8'hFF, 1'b1);
        b_take(4'd1, 2'b00);
        aw_send(4'd2, 32'h8000_0020, 8'd0, INCR);
        w_send(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1);
        b_take(4'd2, 2'b00);
        read1("t2", 4'd2, 32'h8000_0020, 64'h0000_0000_FFFF_FFFF, 2'b00);

        // 3. INCR burst write, read back with rready toggling
        aw_send(4'd7, 32'h8000_0100, 8'd3, INCR);
        for (int i = 0; i < 4; i++) w_send(64'(i + 1), 8'hFF, i == 3);
        b_take(4'd7, 2'b00);
        ar_send(4'd6, 32'h8000_0100, 8'd3, INCR);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t3_rvalid", {63'd0, r_valid}, 64'd1);
            chk("t3_rdata", r_data, 64'(i + 1));
            chk("t3_rlast", {63'd0, r_last}, {63'd0, i == 3});
            r_ready = 1'b0;
            tick();
            chk("t3_rdata_hold", r_data, 64'(i + 1));
            chk("t3_rlast_hold", {63'd0, r_last}, {63'd0, i == 3});
            r_ready = 1'b1;
            tick();
            r_ready = 1'b0;
        end
        chk("t3_rvalid_end", {63'd0, r_valid}, 64'd0);

        // 4. error responses
        read1("t4_below", 4'd4, 32'h7FFF_FFF8, 64'd0, 2'b11);
        read1("t4_above", 4'd4, 32'h8008_0000, 64'd0, 2'b11);
        aw_send(4'd8, 32'h8000_0010, 8'd0, WRAP);
        w_send(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b1);
        b_take(4'd8, 2'b10);
        read1("t4_wrap_keep", 4'd0, 32'h8000_0010, 64'h1122_3344_5566_7788, 2'b00);
        aw_send(4'd9, 32'h8000_0200, 8'd1, INCR);
        w_send(64'hAA, 8'hFF, 1'b1);
        w_send(64'hBB, 8'hFF, 1'b1);
        b_take(4'd9, 2'b10);
        read1("t4_badlast_data", 4'd0, 32'h8000_0208, 64'hBB, 2'b00);
        aw_send(4'd10, 32'h8008_0000, 8'd0, INCR);
        w_send(64'h55, 8'hFF, 1'b1);
        b_take(4'd10, 2'b11);

        // 5. same-cycle read and write of one word; bready held low
        aw_send(4'd11, 32'h8000_0300, 8'd0, INCR);
        w_send(64'h100, 8'hFF, 1'b1);
        b_take(4'd11, 2'b00);
        aw_send(4'd9, 32'h8000_0300, 8'd0, INCR);
        ar_send(4'd12, 32'h8000_0300, 8'd1, FIXED);
        w_data = 64'h200; w_strb = 8'hFF; w_last = 1'b1; w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        chk("t5_rvalid", {63'd0, r_valid}, 64'd1);
        chk("t5_old_data", r_data, 64'h100);
        chk("t5_rlast0", {63'd0, r_last}, 64'd0);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        chk("t5_new_data", r_data, 64'h200);
        chk("t5_rlast1", {63'd0, r_last}, 64'd1);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t5_b_valid_hold", {63'd0, b_valid}, 64'd1);
            chk("t5_b_id_hold", {60'd0, b_id}, 64'd9);
            chk("t5_aw_ready_low", {63'd0, aw_ready}, 64'd0);
            tick();
        end
        b_take(4'd9, 2'b00);

        // 6. reset in the middle of a read burst
        ar_send(4'd13, 32'h8000_0100, 8'd3, INCR);
        tick();
        chk("t6_beat0", r_data, 64'd1);
        r_ready = 1'b1;
        tick(); tick();
        r_ready = 1'b0;
        chk("t6_beat2", r_data, 64'd3);
        rst = 1'b1;
        #1;
        chk("t6_rst_rvalid", {63'd0, r_valid}, 64'd0);
        chk("t6_rst_arready", {63'd0, ar_ready}, 64'd1);
        chk("t6_rst_rlast", {63'd0, r_last}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        read1("t6_after", 4'd14, 32'h8000_0100, 64'd1, 2'b00);
        read1("t6_intact", 4'd15, 32'h8000_0010, 64'h1122_3344_5566_7788, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
